pipe_controller: RTL and testbench
==================================

Name: pipe_controller

Overview:
- Pipelined successor to the single-cycle RV32I control decoder, for the 5-stage core (IF/ID/EX/MEM/WB).
- Decodes the instruction in ID and carries its control fields through EX/MEM/WB stage registers.
- Resolves branches in EX, detects load-use and RAW hazards, and generates stall, flush and forwarding selects.
- ALU shift-immediate decode is corrected: SRAI vs SRLI uses inst[30].

Parameters:
DWIDTH, 32, instruction width; only bits [31:0] are decoded.
AWIDTH, 32, address width; kept for interface consistency, no internal use.
FWD_EN, 1, 1 = forward from MEM/WB; 0 = no forwarding, stall on every RAW hazard.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
inst_d  in  DWIDTH  instruction held in the IF/ID register
valid_d  in  1  inst_d is a real instruction
BrEq  in  1  EX-stage comparator: equal
BrLT  in  1  EX-stage comparator: less-than
ImmSel_d  out  3  immediate format for ID: I=000, S=001, B=010, U=011, J=100
BrUn_e  out  1  unsigned compare for EX branch
ASel_e  out  1  ALU A = PC
BSel_e  out  1  ALU B = immediate
ALUSel_e  out  4  ALU operation
PCSel_e  out  1  redirect PC to the EX ALU result
FwdA_e  out  2  operand A source: 00 = regfile, 01 = MEM ALU result, 10 = WB data
FwdB_e  out  2  operand B source, same encoding as FwdA_e
MemRW_m  out  1  data-memory write
Size_m  out  3  access size/sign (func3)
WBSel_w  out  2  writeback source: 00 = mem, 01 = ALU, 10 = PC+4, 11 = imm (LUI)
RegWEn_w  out  1  regfile write enable
rd_w  out  5  destination register
stall_f  out  1  hold PC
stall_d  out  1  hold the IF/ID register
flush_d  out  1  load a bubble into the IF/ID register

Behaviour:
- Decode uses opcode inst[6:2], func3 inst[14:12], inst[30], rd, rs1 and rs2.
- Opcode classes:
  - R = 01100 / 01110
  - LOAD = 00000
  - OP-IMM = 00100 / 00110
  - JALR = 11001
  - STORE = 01000
  - BRANCH = 11000
  - AUIPC = 00101
  - LUI = 01101
  - JAL = 11011
- ALUSel:
  - R-type: {inst[30], func3}.
  - OP-IMM with func3=101: {inst[30], 101}.
  - Other OP-IMM: {0, func3}.
  - All other classes: 0000.
- ASel = BRANCH, AUIPC or JAL. BSel = not R-type.
- RegWEn = not (STORE or BRANCH), and only when valid.
- MemRW = STORE and valid.
- WBSel: 11 for LUI, 00 for LOAD, 10 for JAL/JALR, 01 otherwise.
- Source-register use: rs1 is used by all classes except LUI, AUIPC and JAL. rs2 is used by R, STORE and BRANCH.
- Stage registers ID->EX->MEM->WB hold valid, control fields, rd, rs1 and rs2.
- Latency: an instruction in ID at cycle n drives the _e outputs at n+1, the _m outputs at n+2 and the _w outputs at n+3.
- BrUn_e = func3_e[2] & func3_e[1].
- Branch-taken rule on func3_e:
  - 000: BrEq
  - 001: !BrEq
  - 100 / 110: BrLT
  - 101 / 111: !BrLT
- PCSel_e = valid_e & (JAL | JALR | (BRANCH & taken)).
- Taken redirect (PCSel_e=1):
  - flush_d=1 in the same cycle.
  - The ID instruction is replaced by a bubble into EX on the next edge.
- Bubble: valid=0, RegWEn=0, MemRW=0, all other fields 0.
- Load-use hazard (FWD_EN=1):
  - Condition: EX holds a valid LOAD with rd!=0, and rd equals a used rs of a valid ID instruction.
  - Response: stall_f=stall_d=1 for one cycle and a bubble into EX.
- FWD_EN=0:
  - Stall while a valid EX or MEM instruction with RegWEn=1 and rd!=0 matches a used rs in ID.
  - WB conflicts need no stall; the regfile is write-before-read.
  - FwdA_e and FwdB_e are held at 00.
- Forwarding (FWD_EN=1), from registered stage fields:
  - Select 01 when MEM is valid, RegWEn_m=1, rd_m!=0 and rd_m equals the EX rs.
  - Otherwise select 10 under the same conditions against WB.
  - MEM has priority over WB.
  - rd=x0 never forwards.
- Flush has priority over stall: on the same cycle, stall_f=stall_d=0 and flush_d=1.
- Stall keeps the EX/MEM/WB stages advancing.
- Reset:
  - Asynchronously clears every stage register, including valid and all outputs, to 0.
  - All outputs read 0 during reset, including mid-operation.
  - First decode occurs on the first edge after release.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) -> at n+1: ALUSel_e=0000, BSel_e=0. At n+3: RegWEn_w=1, rd_w=3, WBSel_w=01.
- ADDI x1,x0,5 (0x00500093) then ADDI x2,x1,1 (0x00108113) -> FwdA_e=01 on the second instruction's EX cycle, no stall.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x5 (0x00528333) -> stall_f=stall_d=1 for exactly one cycle, EX bubble (RegWEn/MemRW=0), then FwdA_e=FwdB_e=10.
- BEQ x0,x0 (0x00000063) with BrEq=1 -> PCSel_e=1 and flush_d=1 in the same cycle; next EX has valid=0. Same test with BNE (func3=001) and BrEq=1 -> PCSel_e=0, no flush.
- FWD_EN=0 with the ADDI pair from scenario 2 -> two stall cycles, FwdA_e=00. SRAI x1,x1,3 (0x4030D093) -> ALUSel_e=1101.
- rst asserted while a store (SW) is in MEM -> MemRW_m=0 immediately, before any clock edge. Also: load to x0 followed by a use of x0 -> no stall.

Source files
------------

// File: rtl/pipe_controller.sv
// pipe_controller
//   Control path for a 5-stage RV32I core (IF/ID/EX/MEM/WB).
//   The instruction sitting in the IF/ID register is decoded in ID. Its
//   control fields then travel through the ID->EX, EX->MEM and MEM->WB
//   stage registers. Branches resolve in EX. Load-use and RAW hazards are
//   detected in ID. Forwarding selects are produced for the EX operands.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   inst_d, valid_d     instruction held in IF/ID and its valid flag
//   BrEq, BrLT          EX-stage comparator results
//   ImmSel_d            immediate format for the ID instruction
//   BrUn_e .. FwdB_e    EX-stage controls (branch compare, ALU, PC redirect, forwarding)
//   MemRW_m, Size_m     MEM-stage data-memory controls
//   WBSel_w, RegWEn_w,
//   rd_w                WB-stage writeback controls
//   stall_f, stall_d,
//   flush_d             front-end hold / bubble controls
module pipe_controller #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] inst_d,
  input  logic              valid_d,
  input  logic              BrEq,
  input  logic              BrLT,
  output logic [2:0]        ImmSel_d,
  output logic              BrUn_e,
  output logic              ASel_e,
  output logic              BSel_e,
  output logic [3:0]        ALUSel_e,
  output logic              PCSel_e,
  output logic [1:0]        FwdA_e,
  output logic [1:0]        FwdB_e,
  output logic              MemRW_m,
  output logic [2:0]        Size_m,
  output logic [1:0]        WBSel_w,
  output logic              RegWEn_w,
  output logic [4:0]        rd_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d
);

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_R32    = 5'b01110;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_IMM32  = 5'b00110;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  // True when a producer's rd is a register actually read by a consumer.
  function automatic logic rs_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic use1,
                                  input logic use2);
    rs_hit = (use1 & (rs1 == rd)) | (use2 & (rs2 == rd));
  endfunction

  // ---------------------------------------------------------------- ID decode
  logic [31:0] inst_s;
  logic [4:0]  opcode_s;
  logic [2:0]  func3_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;

  assign inst_s   = inst_d[31:0];
  assign opcode_s = inst_s[6:2];
  assign func3_s  = inst_s[14:12];
  assign rd_s     = inst_s[11:7];
  assign rs1_s    = inst_s[19:15];
  assign rs2_s    = inst_s[24:20];

  // Bits that carry no control information, gathered to document that they are ignored.
  logic unused_s;
  assign unused_s = ^{inst_s[31], inst_s[29:25], inst_s[1:0], (AWIDTH > 0)};

  logic is_r_s, is_load_s, is_imm_s, is_jalr_s, is_store_s;
  logic is_branch_s, is_auipc_s, is_lui_s, is_jal_s;

  // Opcode class decode.
  always_comb begin
    is_r_s      = 1'b0;
    is_load_s   = 1'b0;
    is_imm_s    = 1'b0;
    is_jalr_s   = 1'b0;
    is_store_s  = 1'b0;
    is_branch_s = 1'b0;
    is_auipc_s  = 1'b0;
    is_lui_s    = 1'b0;
    is_jal_s    = 1'b0;
    case (opcode_s)
      OP_R, OP_R32:     is_r_s      = 1'b1;
      OP_LOAD:          is_load_s   = 1'b1;
      OP_IMM, OP_IMM32: is_imm_s    = 1'b1;
      OP_JALR:          is_jalr_s   = 1'b1;
      OP_STORE:         is_store_s  = 1'b1;
      OP_BRANCH:        is_branch_s = 1'b1;
      OP_AUIPC:         is_auipc_s  = 1'b1;
      OP_LUI:           is_lui_s    = 1'b1;
      OP_JAL:           is_jal_s    = 1'b1;
      default:          is_r_s      = 1'b0;
    endcase
  end

  logic [2:0] imm_sel_s;
  logic [3:0] alu_sel_s;
  logic       asel_s, bsel_s, regwen_s, memrw_s;
  logic [1:0] wbsel_s;
  logic       use_rs1_s, use_rs2_s;

  // Control fields for the ID instruction.
  always_comb begin
    imm_sel_s = 3'b000;
    if (is_store_s) begin
      imm_sel_s = 3'b001;
    end else if (is_branch_s) begin
      imm_sel_s = 3'b010;
    end else if (is_auipc_s | is_lui_s) begin
      imm_sel_s = 3'b011;
    end else if (is_jal_s) begin
      imm_sel_s = 3'b100;
    end else begin
      imm_sel_s = 3'b000;
    end

    // Shift-immediates share func3=101; inst[30] separates SRAI from SRLI.
    alu_sel_s = 4'b0000;
    if (is_r_s) begin
      alu_sel_s = {inst_s[30], func3_s};
    end else if (is_imm_s) begin
      if (func3_s == 3'b101) begin
        alu_sel_s = {inst_s[30], 3'b101};
      end else begin
        alu_sel_s = {1'b0, func3_s};
      end
    end else begin
      alu_sel_s = 4'b0000;
    end

    asel_s   = is_branch_s | is_auipc_s | is_jal_s;
    bsel_s   = ~is_r_s;
    regwen_s = valid_d & ~(is_store_s | is_branch_s);
    memrw_s  = valid_d & is_store_s;

    wbsel_s = 2'b01;
    if (is_lui_s) begin
      wbsel_s = 2'b11;
    end else if (is_load_s) begin
      wbsel_s = 2'b00;
    end else if (is_jal_s | is_jalr_s) begin
      wbsel_s = 2'b10;
    end else begin
      wbsel_s = 2'b01;
    end

    use_rs1_s = ~(is_lui_s | is_auipc_s | is_jal_s);
    use_rs2_s = is_r_s | is_store_s | is_branch_s;
  end

  // ------------------------------------------------------------ stage state
  logic       valid_e_r, is_load_e_r, is_branch_e_r, is_jal_e_r, is_jalr_e_r;
  logic [2:0] func3_e_r;
  logic       asel_e_r, bsel_e_r, regwen_e_r, memrw_e_r;
  logic [3:0] alu_sel_e_r;
  logic [1:0] wbsel_e_r;
  logic [4:0] rd_e_r, rs1_e_r, rs2_e_r;

  logic       valid_m_r, regwen_m_r, memrw_m_r;
  logic [2:0] size_m_r;
  logic [1:0] wbsel_m_r;
  logic [4:0] rd_m_r;

  logic       valid_w_r, regwen_w_r;
  logic [1:0] wbsel_w_r;
  logic [4:0] rd_w_r;

  // ------------------------------------------------------- branch / hazards
  logic taken_s, pcsel_s, hazard_s, bubble_s;
  logic load_use_s, raw_e_s, raw_m_s;

  // Branch condition from the EX func3.
  always_comb begin
    taken_s = 1'b0;
    case (func3_e_r)
      3'b000:         taken_s = BrEq;
      3'b001:         taken_s = ~BrEq;
      3'b100, 3'b110: taken_s = BrLT;
      3'b101, 3'b111: taken_s = ~BrLT;
      default:        taken_s = 1'b0;
    endcase
  end

  assign pcsel_s = valid_e_r & (is_jal_e_r | is_jalr_e_r | (is_branch_e_r & taken_s));

  // Hazard detection against the older instructions in EX and MEM.
  always_comb begin
    load_use_s = valid_d & valid_e_r & is_load_e_r & (rd_e_r != 5'd0) &
                 rs_hit(rd_e_r, rs1_s, rs2_s, use_rs1_s, use_rs2_s);
    raw_e_s    = valid_d & valid_e_r & regwen_e_r & (rd_e_r != 5'd0) &
                 rs_hit(rd_e_r, rs1_s, rs2_s, use_rs1_s, use_rs2_s);
    raw_m_s    = valid_d & valid_m_r & regwen_m_r & (rd_m_r != 5'd0) &
                 rs_hit(rd_m_r, rs1_s, rs2_s, use_rs1_s, use_rs2_s);
    if (FWD_EN != 0) begin
      hazard_s = load_use_s;
    end else begin
      hazard_s = raw_e_s | raw_m_s;
    end
  end

  // Anything that must not advance from ID becomes a bubble in EX.
  assign bubble_s = ~valid_d | pcsel_s | hazard_s;

  // ID->EX stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e_r     <= 1'b0;
      is_load_e_r   <= 1'b0;
      is_branch_e_r <= 1'b0;
      is_jal_e_r    <= 1'b0;
      is_jalr_e_r   <= 1'b0;
      func3_e_r     <= 3'b000;
      asel_e_r      <= 1'b0;
      bsel_e_r      <= 1'b0;
      alu_sel_e_r   <= 4'b0000;
      regwen_e_r    <= 1'b0;
      memrw_e_r     <= 1'b0;
      wbsel_e_r     <= 2'b00;
      rd_e_r        <= 5'd0;
      rs1_e_r       <= 5'd0;
      rs2_e_r       <= 5'd0;
    end else if (bubble_s) begin
      valid_e_r     <= 1'b0;
      is_load_e_r   <= 1'b0;
      is_branch_e_r <= 1'b0;
      is_jal_e_r    <= 1'b0;
      is_jalr_e_r   <= 1'b0;
      func3_e_r     <= 3'b000;
      asel_e_r      <= 1'b0;
      bsel_e_r      <= 1'b0;
      alu_sel_e_r   <= 4'b0000;
      regwen_e_r    <= 1'b0;
      memrw_e_r     <= 1'b0;
      wbsel_e_r     <= 2'b00;
      rd_e_r        <= 5'd0;
      rs1_e_r       <= 5'd0;
      rs2_e_r       <= 5'd0;
    end else begin
      valid_e_r     <= 1'b1;
      is_load_e_r   <= is_load_s;
      is_branch_e_r <= is_branch_s;
      is_jal_e_r    <= is_jal_s;
      is_jalr_e_r   <= is_jalr_s;
      func3_e_r     <= func3_s;
      asel_e_r      <= asel_s;
      bsel_e_r      <= bsel_s;
      alu_sel_e_r   <= alu_sel_s;
      regwen_e_r    <= regwen_s;
      memrw_e_r     <= memrw_s;
      wbsel_e_r     <= wbsel_s;
      rd_e_r        <= rd_s;
      // Unread source fields are stored as x0 so they can never match a producer.
      rs1_e_r       <= use_rs1_s ? rs1_s : 5'd0;
      rs2_e_r       <= use_rs2_s ? rs2_s : 5'd0;
    end
  end

  // EX->MEM stage register; keeps advancing while the front end stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_m_r  <= 1'b0;
      regwen_m_r <= 1'b0;
      memrw_m_r  <= 1'b0;
      size_m_r   <= 3'b000;
      wbsel_m_r  <= 2'b00;
      rd_m_r     <= 5'd0;
    end else begin
      valid_m_r  <= valid_e_r;
      regwen_m_r <= regwen_e_r;
      memrw_m_r  <= memrw_e_r;
      size_m_r   <= func3_e_r;
      wbsel_m_r  <= wbsel_e_r;
      rd_m_r     <= rd_e_r;
    end
  end

  // MEM->WB stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_w_r  <= 1'b0;
      regwen_w_r <= 1'b0;
      wbsel_w_r  <= 2'b00;
      rd_w_r     <= 5'd0;
    end else begin
      valid_w_r  <= valid_m_r;
      regwen_w_r <= regwen_m_r;
      wbsel_w_r  <= wbsel_m_r;
      rd_w_r     <= rd_m_r;
    end
  end

  // ------------------------------------------------------------ forwarding
  logic [1:0] fwd_a_s, fwd_b_s;
  logic       mem_src_s, wb_src_s;

  // Operand source selects for EX; MEM is the younger result and wins over WB.
  always_comb begin
    mem_src_s = valid_m_r & regwen_m_r & (rd_m_r != 5'd0);
    wb_src_s  = valid_w_r & regwen_w_r & (rd_w_r != 5'd0);
    fwd_a_s   = 2'b00;
    fwd_b_s   = 2'b00;
    if (FWD_EN != 0) begin
      if (mem_src_s & (rd_m_r == rs1_e_r)) begin
        fwd_a_s = 2'b01;
      end else if (wb_src_s & (rd_w_r == rs1_e_r)) begin
        fwd_a_s = 2'b10;
      end else begin
        fwd_a_s = 2'b00;
      end
      if (mem_src_s & (rd_m_r == rs2_e_r)) begin
        fwd_b_s = 2'b01;
      end else if (wb_src_s & (rd_w_r == rs2_e_r)) begin
        fwd_b_s = 2'b10;
      end else begin
        fwd_b_s = 2'b00;
      end
    end else begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end
  end

  // ---------------------------------------------------------------- outputs
  // ImmSel_d is decoded straight from IF/ID, so it is forced low while in reset.
  assign ImmSel_d = rst ? 3'b000 : imm_sel_s;
  assign BrUn_e   = func3_e_r[2] & func3_e_r[1];
  assign ASel_e   = asel_e_r;
  assign BSel_e   = bsel_e_r;
  assign ALUSel_e = alu_sel_e_r;
  assign PCSel_e  = pcsel_s;
  assign FwdA_e   = fwd_a_s;
  assign FwdB_e   = fwd_b_s;
  assign MemRW_m  = memrw_m_r;
  assign Size_m   = size_m_r;
  assign WBSel_w  = wbsel_w_r;
  assign RegWEn_w = regwen_w_r;
  assign rd_w     = rd_w_r;
  // A redirect discards the ID instruction, so it overrides any stall.
  assign stall_f  = hazard_s & ~pcsel_s;
  assign stall_d  = hazard_s & ~pcsel_s;
  assign flush_d  = pcsel_s;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: instance u_a forwards (FWD_EN=1),
// instance u_b does not (FWD_EN=0). Stimulus pushes {cycle, signal, value}
// expectations; a negedge monitor compares and retires them.
module tb_pipe_controller;

  localparam int S_IMM = 0,  S_BRUN = 1,  S_ASEL = 2,   S_BSEL = 3;
  localparam int S_ALU = 4,  S_PCSEL = 5, S_FWDA = 6,   S_FWDB = 7;
  localparam int S_MEMRW = 8, S_SIZE = 9, S_WBSEL = 10, S_REGWEN = 11;
  localparam int S_RDW = 12, S_STF = 13,  S_STD = 14,   S_FLUSH = 15;
  localparam int B = 16;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ADDI1 = 32'h00500093;
  localparam logic [31:0] I_ADDI7 = 32'h00700093;
  localparam logic [31:0] I_ADDI2 = 32'h00108113;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_ADD6  = 32'h00528333;
  localparam logic [31:0] I_BEQ   = 32'h00000063;
  localparam logic [31:0] I_BNE   = 32'h00001063;
  localparam logic [31:0] I_BLTU  = 32'h00006063;
  localparam logic [31:0] I_SRAI  = 32'h4030D093;
  localparam logic [31:0] I_SRLI  = 32'h0030D093;
  localparam logic [31:0] I_LW0   = 32'h0000A003;
  localparam logic [31:0] I_ADD00 = 32'h00000333;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_NOP   = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_a = 32'h0, inst_b = 32'h0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        br_eq = 1'b0, br_lt = 1'b0;

  logic [2:0] a_imm, b_imm, a_size, b_size;
  logic       a_brun, b_brun, a_asel, b_asel, a_bsel, b_bsel, a_pcsel, b_pcsel;
  logic [3:0] a_alu, b_alu;
  logic [1:0] a_fwda, b_fwda, a_fwdb, b_fwdb, a_wbsel, b_wbsel;
  logic       a_memrw, b_memrw, a_regwen, b_regwen;
  logic [4:0] a_rdw, b_rdw;
  logic       a_stf, b_stf, a_std, b_std, a_flush, b_flush;

  pipe_controller #(.DWIDTH(32), .AWIDTH(32), .FWD_EN(1)) u_a (
    .clk(clk), .rst(rst), .inst_d(inst_a), .valid_d(valid_a), .BrEq(br_eq), .BrLT(br_lt),
    .ImmSel_d(a_imm), .BrUn_e(a_brun), .ASel_e(a_asel), .BSel_e(a_bsel), .ALUSel_e(a_alu),
    .PCSel_e(a_pcsel), .FwdA_e(a_fwda), .FwdB_e(a_fwdb), .MemRW_m(a_memrw), .Size_m(a_size),
    .WBSel_w(a_wbsel), .RegWEn_w(a_regwen), .rd_w(a_rdw), .stall_f(a_stf), .stall_d(a_std),
    .flush_d(a_flush));

  pipe_controller #(.DWIDTH(32), .AWIDTH(32), .FWD_EN(0)) u_b (
    .clk(clk), .rst(rst), .inst_d(inst_b), .valid_d(valid_b), .BrEq(br_eq), .BrLT(br_lt),
    .ImmSel_d(b_imm), .BrUn_e(b_brun), .ASel_e(b_asel), .BSel_e(b_bsel), .ALUSel_e(b_alu),
    .PCSel_e(b_pcsel), .FwdA_e(b_fwda), .FwdB_e(b_fwdb), .MemRW_m(b_memrw), .Size_m(b_size),
    .WBSel_w(b_wbsel), .RegWEn_w(b_regwen), .rd_w(b_rdw), .stall_f(b_stf), .stall_d(b_std),
    .flush_d(b_flush));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] obs [32];
  always_comb begin
    obs[0]  = {2'b00, a_imm};   obs[1]  = {4'b0, a_brun};  obs[2]  = {4'b0, a_asel};
    obs[3]  = {4'b0, a_bsel};   obs[4]  = {1'b0, a_alu};   obs[5]  = {4'b0, a_pcsel};
    obs[6]  = {3'b0, a_fwda};   obs[7]  = {3'b0, a_fwdb};  obs[8]  = {4'b0, a_memrw};
    obs[9]  = {2'b00, a_size};  obs[10] = {3'b0, a_wbsel}; obs[11] = {4'b0, a_regwen};
    obs[12] = a_rdw;            obs[13] = {4'b0, a_stf};   obs[14] = {4'b0, a_std};
    obs[15] = {4'b0, a_flush};
    obs[16] = {2'b00, b_imm};   obs[17] = {4'b0, b_brun};  obs[18] = {4'b0, b_asel};
    obs[19] = {4'b0, b_bsel};   obs[20] = {1'b0, b_alu};   obs[21] = {4'b0, b_pcsel};
    obs[22] = {3'b0, b_fwda};   obs[23] = {3'b0, b_fwdb};  obs[24] = {4'b0, b_memrw};
    obs[25] = {2'b00, b_size};  obs[26] = {3'b0, b_wbsel}; obs[27] = {4'b0, b_regwen};
    obs[28] = b_rdw;            obs[29] = {4'b0, b_stf};   obs[30] = {4'b0, b_std};
    obs[31] = {4'b0, b_flush};
  end

  string names [16] = '{"ImmSel_d", "BrUn_e", "ASel_e", "BSel_e", "ALUSel_e", "PCSel_e",
                        "FwdA_e", "FwdB_e", "MemRW_m", "Size_m", "WBSel_w", "RegWEn_w",
                        "rd_w", "stall_f", "stall_d", "flush_d"};

  typedef struct {
    int         at;
    int         sig;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  task automatic want(input int at, input int sig, input logic [4:0] val);
    exp_t e;
    e.at = at; e.sig = sig; e.val = val;
    sb.push_back(e);
  endtask

  // Monitor: retire every expectation that falls due in this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checks = checks + 1;
        if (obs[sb[i].sig] === sb[i].val) begin
          passed = passed + 1;
        end else begin
          $display("FAIL %s%s cycle %0d: got %0d expected %0d", names[sb[i].sig % 16],
                   (sb[i].sig >= B) ? "(fwd_off)" : "", cyc, obs[sb[i].sig], sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic drive(input bit b, input logic [31:0] ins, input logic v,
                       input logic eq, input logic lt);
    if (b) begin
      inst_b = ins; valid_b = v; inst_a = I_NOP; valid_a = 1'b0;
    end else begin
      inst_a = ins; valid_a = v; inst_b = I_NOP; valid_b = 1'b0;
    end
    br_eq = eq;
    br_lt = lt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit b, input logic [31:0] ins, input logic v,
                      input logic eq, input logic lt);
    drive(b, ins, v, eq, lt);
    tick();
  endtask

  int n;

  initial begin
    // Reset: a store presented during reset must neither decode nor enter the pipe.
    rst = 1'b1;
    tick(); tick();
    drive(1'b0, I_SW, 1'b1, 1'b0, 1'b0);
    want(cyc, S_IMM, 5'd0); want(cyc, S_MEMRW, 5'd0); want(cyc, S_REGWEN, 5'd0);
    want(cyc, B + S_STF, 5'd0);
    tick();
    rst = 1'b0;
    n = cyc;
    want(n + 1, S_BSEL, 5'd0); want(n + 2, S_MEMRW, 5'd0);
    step(1'b0, I_NOP, 1'b0, 1'b0, 1'b0);

    // ADD x3,x1,x2
    n = cyc;
    want(n, S_IMM, 5'd0); want(n + 1, S_ALU, 5'd0); want(n + 1, S_BSEL, 5'd0);
    want(n + 1, S_ASEL, 5'd0); want(n + 2, S_MEMRW, 5'd0);
    want(n + 3, S_REGWEN, 5'd1); want(n + 3, S_RDW, 5'd3); want(n + 3, S_WBSEL, 5'd1);
    step(1'b0, I_ADD, 1'b1, 1'b0, 1'b0);

    // ADDI x1,x0,5 ; ADDI x2,x1,1 : MEM forward, no stall
    n = cyc;
    want(n + 1, S_BSEL, 5'd1); want(n + 1, S_STF, 5'd0); want(n + 1, S_STD, 5'd0);
    want(n + 2, S_FWDA, 5'd1);
    step(1'b0, I_ADDI1, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_ADDI2, 1'b1, 1'b0, 1'b0);

    // LW x5,0(x1) ; ADD x6,x5,x5 : one stall, bubble, then WB forward
    n = cyc;
    want(n + 1, S_FWDA, 5'd2);
    want(n + 1, S_STF, 5'd1); want(n + 1, S_STD, 5'd1); want(n + 1, S_FLUSH, 5'd0);
    want(n + 2, S_STF, 5'd0); want(n + 2, S_SIZE, 5'd2);
    want(n + 3, S_FWDA, 5'd2); want(n + 3, S_FWDB, 5'd2); want(n + 3, S_MEMRW, 5'd0);
    want(n + 3, S_REGWEN, 5'd1); want(n + 3, S_RDW, 5'd5); want(n + 3, S_WBSEL, 5'd0);
    want(n + 4, S_REGWEN, 5'd0); want(n + 5, S_RDW, 5'd6);
    step(1'b0, I_LW, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_ADD6, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_ADD6, 1'b1, 1'b0, 1'b0);

    // Load to x0 then use of x0: no stall, no forwarding
    n = cyc;
    want(n + 1, S_STF, 5'd0); want(n + 2, S_FWDA, 5'd0); want(n + 2, S_FWDB, 5'd0);
    step(1'b0, I_LW0, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_ADD00, 1'b1, 1'b0, 1'b0);

    // MEM result wins over WB when both write x1
    n = cyc;
    want(n + 2, S_FWDA, 5'd0); want(n + 3, S_FWDA, 5'd1);
    step(1'b0, I_ADDI1, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_ADDI7, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_ADDI2, 1'b1, 1'b0, 1'b0);

    // BEQ taken: redirect + flush, EX bubble follows
    n = cyc;
    want(n + 1, S_PCSEL, 5'd1); want(n + 1, S_FLUSH, 5'd1); want(n + 1, S_STF, 5'd0);
    want(n + 1, S_ASEL, 5'd1); want(n + 1, S_BRUN, 5'd0);
    want(n + 2, S_BSEL, 5'd0); want(n + 3, S_REGWEN, 5'd0); want(n + 4, S_REGWEN, 5'd0);
    step(1'b0, I_BEQ, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_ADDI1, 1'b1, 1'b1, 1'b0);
    step(1'b0, I_NOP, 1'b0, 1'b0, 1'b0);

    // BNE with BrEq=1: not taken, following ADDI proceeds
    n = cyc;
    want(n + 1, S_PCSEL, 5'd0); want(n + 1, S_FLUSH, 5'd0);
    want(n + 2, S_BSEL, 5'd1); want(n + 4, S_REGWEN, 5'd1); want(n + 4, S_RDW, 5'd1);
    step(1'b0, I_BNE, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_ADDI1, 1'b1, 1'b1, 1'b0);
    step(1'b0, I_NOP, 1'b0, 1'b0, 1'b0);

    // BLTU twice: unsigned compare, not taken then taken
    n = cyc;
    want(n + 1, S_BRUN, 5'd1); want(n + 1, S_PCSEL, 5'd0);
    want(n + 2, S_PCSEL, 5'd1); want(n + 2, S_FLUSH, 5'd1);
    step(1'b0, I_BLTU, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_BLTU, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_NOP, 1'b0, 1'b0, 1'b1);

    // SRAI vs SRLI
    n = cyc;
    want(n + 1, S_ALU, 5'd13); want(n + 2, S_ALU, 5'd5);
    step(1'b0, I_SRAI, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_SRLI, 1'b1, 1'b0, 1'b0);

    // SW reaches MEM normally
    n = cyc;
    want(n, S_IMM, 5'd1); want(n + 2, S_MEMRW, 5'd1); want(n + 2, S_SIZE, 5'd2);
    want(n + 3, S_REGWEN, 5'd0);
    step(1'b0, I_SW, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_NOP, 1'b0, 1'b0, 1'b0);
    step(1'b0, I_NOP, 1'b0, 1'b0, 1'b0);
    step(1'b0, I_NOP, 1'b0, 1'b0, 1'b0);

    // SW in MEM when reset hits between edges: MemRW_m drops immediately
    step(1'b0, I_SW, 1'b1, 1'b0, 1'b0);
    step(1'b0, I_NOP, 1'b0, 1'b0, 1'b0);
    want(cyc, S_MEMRW, 5'd0); want(cyc, S_SIZE, 5'd0);
    checks = checks + 1;
    if (a_memrw === 1'b1) begin
      passed = passed + 1;
    end else begin
      $display("FAIL MemRW_m before reset: got %0d expected 1", a_memrw);
    end
    checks = checks + 1;
    if (a_size === 3'b010) begin
      passed = passed + 1;
    end else begin
      $display("FAIL Size_m before reset: got %0d expected 2", a_size);
    end
    rst = 1'b1;
    #1;
    checks = checks + 1;
    if (a_memrw === 1'b0) begin
      passed = passed + 1;
    end else begin
      $display("FAIL MemRW_m async reset: got %0d expected 0", a_memrw);
    end
    checks = checks + 1;
    if (a_size === 3'b000) begin
      passed = passed + 1;
    end else begin
      $display("FAIL Size_m async reset: got %0d expected 0", a_size);
    end
    checks = checks + 1;
    if (a_regwen === 1'b0) begin
      passed = passed + 1;
    end else begin
      $display("FAIL RegWEn_w async reset: got %0d expected 0", a_regwen);
    end
    checks = checks + 1;
    if (a_rdw === 5'd0) begin
      passed = passed + 1;
    end else begin
      $display("FAIL rd_w async reset: got %0d expected 0", a_rdw);
    end
    tick();
    rst = 1'b0;
    step(1'b0, I_NOP, 1'b0, 1'b0, 1'b0);

    // FWD_EN=0: ADDI pair stalls twice, no forwarding
    n = cyc;
    want(n + 1, B + S_STF, 5'd1); want(n + 1, B + S_STD, 5'd1);
    want(n + 2, B + S_STF, 5'd1); want(n + 2, B + S_BSEL, 5'd0);
    want(n + 3, B + S_STF, 5'd0);
    want(n + 4, B + S_FWDA, 5'd0); want(n + 4, B + S_BSEL, 5'd1);
    want(n + 6, B + S_REGWEN, 5'd1); want(n + 6, B + S_RDW, 5'd2);
    step(1'b1, I_ADDI1, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_ADDI2, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_ADDI2, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_ADDI2, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_NOP, 1'b0, 1'b0, 1'b0);

    // FWD_EN=0: JAL in EX with a RAW hazard in ID -> flush beats stall
    n = cyc;
    want(n + 1, B + S_STF, 5'd0);
    want(n + 2, B + S_PCSEL, 5'd1); want(n + 2, B + S_FLUSH, 5'd1);
    want(n + 2, B + S_STF, 5'd0); want(n + 2, B + S_STD, 5'd0);
    want(n + 3, B + S_BSEL, 5'd0); want(n + 4, B + S_WBSEL, 5'd2);
    step(1'b1, I_ADDI1, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_JAL, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_ADDI2, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_NOP, 1'b0, 1'b0, 1'b0);

    repeat (6) tick();

    // Anything still queued was never reached by the monitor.
    foreach (sb[i]) begin
      checks = checks + 1;
      $display("FAIL %s unchecked: due cycle %0d expected %0d", names[sb[i].sig % 16],
               sb[i].at, sb[i].val);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
